// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_mmio_ctrl
// Brief   : Memory-mapped UART controller. Queues CPU transmit bytes in a
//           small FIFO, hands them to the sender one at a time through a
//           start/busy handshake, holds received bytes, and raises a level
//           interrupt from the status/enable bits in CON.
// Revision: 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000018,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam logic [31:0]    c_ADDR_TXD = BASE_ADDR;
  localparam logic [31:0]    c_ADDR_RXD = BASE_ADDR + 32'd4;
  localparam logic [31:0]    c_ADDR_CON = BASE_ADDR + 32'd8;
  localparam logic [PTR_W:0] c_DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_LOAD    = 3'd1;
  localparam logic [2:0] c_ST_START   = 3'd2;
  localparam logic [2:0] c_ST_WAIT_HI = 3'd3;
  localparam logic [2:0] c_ST_WAIT_LO = 3'd4;
  localparam logic [2:0] c_ST_DONE    = 3'd5;

  // TX FIFO
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_last_push;

  // TX sequencer
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_tx_data;

  // Control / status
  logic       r_tx_ie;
  logic       r_rx_ie;
  logic       r_tx_done;
  logic       r_rx_full;
  logic       r_tx_ovf;
  logic       r_rx_ovr;
  logic [7:0] r_rx_hold;
  logic       r_irq;

  // Bus decode
  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_txd_wr, w_con_wr, w_con_rd, w_rxd_rd;
  logic w_full, w_empty, w_push, w_pop, w_ovf_set, w_rx_ovr_set;
  logic w_tx_active;
  logic [31:0] w_con_word;
  logic w_unused;

  assign w_sel_txd = (addr == c_ADDR_TXD);
  assign w_sel_rxd = (addr == c_ADDR_RXD);
  assign w_sel_con = (addr == c_ADDR_CON);

  assign w_txd_wr = mem_write & w_sel_txd;
  assign w_con_wr = mem_write & w_sel_con;
  assign w_con_rd = mem_read  & w_sel_con;
  assign w_rxd_rd = mem_read  & w_sel_rxd;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  // The sequencer only enters LOAD with the FIFO non-empty, so a pop is
  // always valid there. A pop in the same cycle frees a slot for a push.
  assign w_pop     = (r_state == c_ST_LOAD);
  assign w_push    = w_txd_wr & (~w_full | w_pop);
  assign w_ovf_set = w_txd_wr & w_full & ~w_pop;

  // An RXD read in the same cycle consumes the old byte, so no overrun.
  assign w_rx_ovr_set = rx_valid & r_rx_full & ~w_rxd_rd;

  assign w_tx_active = ~w_empty | (r_state != c_ST_IDLE);

  assign w_con_word = {24'b0, r_rx_ovr, r_tx_ovf, w_full, w_tx_active,
                       r_rx_full, r_tx_done, r_rx_ie, r_tx_ie};

  assign w_unused = ^wdata[31:8];

  assign tx_data  = r_tx_data;
  assign tx_start = (r_state == c_ST_START);
  assign irq      = r_irq;

  // Read data mux; zero when no read strobe or no register matches
  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (w_sel_txd)      rdata = {24'b0, r_last_push};
      else if (w_sel_rxd) rdata = {24'b0, r_rx_hold};
      else if (w_sel_con) rdata = w_con_word;
    end
  end

  // FIFO storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy and the last accepted TXD byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_push <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_last_push <= wdata[7:0];
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sender sequencing: one byte per start pulse, wait for busy to rise then fall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (!w_empty) w_state_nxt = c_ST_LOAD;
      c_ST_LOAD:    w_state_nxt = c_ST_START;
      c_ST_START:   w_state_nxt = c_ST_WAIT_HI;
      c_ST_WAIT_HI: if (tx_busy) w_state_nxt = c_ST_WAIT_LO;
      c_ST_WAIT_LO: if (!tx_busy) w_state_nxt = c_ST_DONE;
      c_ST_DONE:    w_state_nxt = w_empty ? c_ST_IDLE : c_ST_LOAD;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register and the byte held stable for the sender
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_tx_data <= r_fifo[r_rd_ptr];
    end
  end

  // CON bits and RX holding register; a set event beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_ie   <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_tx_done <= 1'b0;
      r_rx_full <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_rx_hold <= '0;
    end else begin
      if (w_con_wr) begin
        r_tx_ie <= wdata[0];
        r_rx_ie <= wdata[1];
      end

      if (r_state == c_ST_DONE) r_tx_done <= 1'b1;
      else if (w_con_rd)        r_tx_done <= 1'b0;

      if (w_ovf_set)     r_tx_ovf <= 1'b1;
      else if (w_con_rd) r_tx_ovf <= 1'b0;

      if (w_rx_ovr_set)  r_rx_ovr <= 1'b1;
      else if (w_con_rd) r_rx_ovr <= 1'b0;

      if (rx_valid) begin
        r_rx_hold <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rxd_rd) begin
        r_rx_full <= 1'b0;
      end
    end
  end

  // Registered interrupt, one cycle behind its source bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_full);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_mmio_ctrl
// Brief   : Scoreboard bench for uart_mmio_ctrl. Expected TX bytes and read
//           data are queued by the stimulus; monitors pop and compare when
//           the DUT presents tx_start or a CPU read.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_mmio_ctrl;

  localparam logic [31:0] c_TXD = 32'h40000018;
  localparam logic [31:0] c_RXD = 32'h4000001C;
  localparam logic [31:0] c_CON = 32'h40000020;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int busy_len = 10;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd_val[$];
  string       exp_rd_name[$];
  logic [7:0]  mon_tx;
  logic [31:0] mon_rd;
  string       mon_nm;

  uart_mmio_ctrl #(
    .BASE_ADDR (32'h40000018),
    .FIFO_DEPTH(4),
    .PTR_W     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus tasks start #1 after a posedge and hold the strobe for one cycle
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_rd_val.push_back(e);
    exp_rd_name.push_back(nm);
    addr = a; mem_read = 1'b1;
    tick();
    mem_read = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_busy_fall(input string nm);
    int n = 0;
    while (!tx_busy && n < 100) begin @(posedge clk); #2; n++; end
    while (tx_busy && n < 200) begin @(posedge clk); #2; n++; end
    check({nm, "_busy_timeout"}, {31'b0, tx_busy}, 32'd0);
  endtask

  task automatic wait_tx_drained(input string nm);
    int n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin tick(); n++; end
    check({nm, "_drain_timeout"}, exp_tx.size(), 32'd0);
  endtask

  // Sender model: busy rises after the start pulse, falls busy_len cycles later
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
          @(posedge clk);
          if (reset) break;
        end
        #1 tx_busy = 1'b0;
      end
    end
  end

  // TX monitor: every start pulse must match the next queued byte
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      n_checks++;
      if (exp_tx.size() == 0) begin
        n_errors++;
        $display("FAIL tx_start_unexpected: got tx_data 0x%02h, expected no start", tx_data);
      end else begin
        mon_tx = exp_tx.pop_front();
        if (tx_data !== mon_tx) begin
          n_errors++;
          $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, mon_tx);
        end
      end
    end
  end

  // Read monitor: every CPU read must match the next queued value
  always @(negedge clk) begin
    if (!reset && mem_read) begin
      n_checks++;
      if (exp_rd_val.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no read", rdata);
      end else begin
        mon_rd = exp_rd_val.pop_front();
        mon_nm = exp_rd_name.pop_front();
        if (rdata !== mon_rd) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_nm, rdata, mon_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    wdata = '0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    rd_reg(c_CON, 32'h0, "rst_con");
    rd_reg(c_RXD, 32'h0, "rst_rxd");

    // Single byte: start pulse on the third cycle counting the write cycle as 0
    wr_reg(c_CON, 32'h1);
    exp_tx.push_back(8'h55);
    wr_reg(c_TXD, 32'h55);
    check("lat_c1_start", {31'b0, tx_start}, 32'd0);
    tick();
    check("lat_c2_start", {31'b0, tx_start}, 32'd0);
    tick();
    check("lat_c3_start", {31'b0, tx_start}, 32'd1);
    check("lat_c3_data", {24'b0, tx_data}, 32'h55);
    wait_busy_fall("t2");
    tick();
    tick();
    check("t2_irq_before", {31'b0, irq}, 32'd0);
    rd_reg(c_CON, 32'h05, "t2_con_done");
    check("t2_irq_set", {31'b0, irq}, 32'd1);
    rd_reg(c_CON, 32'h01, "t2_con_cleared");
    check("t2_irq_clr", {31'b0, irq}, 32'd0);
    wr_reg(c_CON, 32'h0);

    // Burst of five: FIFO holds three at the fifth edge, so nothing dropped
    for (int i = 1; i <= 5; i++) begin
      exp_tx.push_back(8'(i));
      wr_reg(c_TXD, 32'(i));
    end
    wr_reg(c_TXD, 32'h06);                 // FIFO full, sender busy: dropped
    rd_reg(c_CON, 32'h70, "t3_con_ovf");
    rd_reg(c_CON, 32'h30, "t3_con_ovf_clr");
    wait_busy_fall("t3");
    tick();
    tick();
    exp_tx.push_back(8'h07);
    wr_reg(c_TXD, 32'h07);                 // lands on the LOAD edge of a full FIFO
    rd_reg(c_CON, 32'h34, "t3_con_pushpop");
    rd_reg(c_TXD, 32'h07, "t3_txd_last");
    wait_tx_drained("t3");
    wait_busy_fall("t3_last");
    tick();
    tick();
    rd_reg(c_CON, 32'h04, "t3_con_idle");

    // RX capture and interrupt; upper CON write bits ignored
    wr_reg(c_CON, 32'hFFFF_FFFE);
    rx_pulse(8'hA3);
    check("t4_irq_lag", {31'b0, irq}, 32'd0);
    tick();
    check("t4_irq_set", {31'b0, irq}, 32'd1);
    rd_reg(c_CON, 32'h0A, "t4_con_rxfull");
    rd_reg(c_RXD, 32'hA3, "t4_rxd");
    check("t4_irq_hold", {31'b0, irq}, 32'd1);
    tick();
    check("t4_irq_clr", {31'b0, irq}, 32'd0);

    // Overrun, and set-wins-over-clear cases
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd_reg(c_RXD, 32'h22, "t5_rxd_overwrite");
    rd_reg(c_CON, 32'h82, "t5_con_ovr");
    rx_data = 8'h33; rx_valid = 1'b1;
    rd_reg(c_RXD, 32'h22, "t5_rxd_coinc_empty");
    rd_reg(c_CON, 32'h0A, "t5_con_full_kept");
    rx_data = 8'h44; rx_valid = 1'b1;
    rd_reg(c_RXD, 32'h33, "t5_rxd_coinc_full");
    rd_reg(c_CON, 32'h0A, "t5_con_no_ovr");
    rx_data = 8'h66; rx_valid = 1'b1;
    rd_reg(c_CON, 32'h0A, "t5_con_coinc_ovr");
    rd_reg(c_CON, 32'h8A, "t5_con_ovr_kept");
    wr_reg(c_RXD, 32'h99);
    rd_reg(c_RXD, 32'h66, "t5_rxd_wr_ignored");
    rd_reg(c_CON + 32'd4, 32'h0, "t5_unmapped");
    rd_reg(c_TXD + 32'd1, 32'h0, "t5_unaligned");
    addr = c_CON;
    #1 check("t5_rdata_no_strobe", rdata, 32'h0);

    // Reset in WAIT_LO with two bytes still queued
    wr_reg(c_CON, 32'h3);
    rx_pulse(8'h77);
    tick();
    check("t6_irq_pre", {31'b0, irq}, 32'd1);
    busy_len = 6;
    exp_tx.push_back(8'hAA);
    wr_reg(c_TXD, 32'hAA);
    wr_reg(c_TXD, 32'hBB);
    wr_reg(c_TXD, 32'hCC);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("t6_rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("t6_rst_irq", {31'b0, irq}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (30) tick();
    rd_reg(c_CON, 32'h0, "t6_con_after_rst");
    exp_tx.push_back(8'h5A);
    wr_reg(c_TXD, 32'h5A);
    wait_tx_drained("t6");
    wait_busy_fall("t6");
    repeat (3) tick();

    check("end_tx_queue", exp_tx.size(), 32'd0);
    check("end_rd_queue", exp_rd_val.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller that sits between the single-cycle MIPS core's data bus and the UART sender/receiver pair. It buffers CPU transmit bytes in a small FIFO and sequences the sender one byte at a time through a start/busy handshake. It captures received bytes into a holding register and exposes status and interrupt-enable bits through a control register. It drives one level interrupt to the CPU.

Parameters:
BASE_ADDR, 32'h40000018, byte address of TXD; RXD at BASE_ADDR+4, CON at BASE_ADDR+8
FIFO_DEPTH, 4, TX FIFO entries, power of two, minimum 2
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
addr  input  32  CPU byte address
mem_read  input  1  CPU read strobe, one cycle per access
mem_write  input  1  CPU write strobe, one cycle per access
wdata  input  32  CPU write data
rdata  output  32  CPU read data, combinational
tx_data  output  8  byte to sender, held stable from tx_start until busy falls
tx_start  output  1  one-cycle start pulse to sender
tx_busy  input  1  sender busy
rx_data  input  8  byte from receiver
rx_valid  input  1  one-cycle pulse, rx_data valid
irq  output  1  level interrupt to CPU

Behaviour:
- Reset (async): FIFO empty, pointers 0, FSM IDLE, tx_start=0, tx_data=0, rx_hold=0, all CON bits 0, irq=0.
- Address decode: only exact word addresses match. rdata=0 when mem_read=0 or the address is unmatched. Writes to RXD or to unmatched addresses are ignored.
- TXD write (mem_write, addr==BASE): push wdata[7:0] when the FIFO is not full. When full, drop the byte and set tx_ovf. TXD reads return {24'b0, last pushed byte}.
- RXD read: returns {24'b0, rx_hold} and clears rx_full at the clock edge.
- CON layout, rdata bits:
  - [0] tx_ie, R/W
  - [1] rx_ie, R/W
  - [2] tx_done, sticky
  - [3] rx_full
  - [4] tx_active = FIFO non-empty or FSM not IDLE
  - [5] fifo_full
  - [6] tx_ovf, sticky
  - [7] rx_ovr, sticky
  - [31:8] = 0
- CON write: updates only bits [1:0].
- CON read: clears tx_done, tx_ovf and rx_ovr at the edge.
- A set event in the same cycle as a clearing access wins, so the bit stays 1. This applies to the CON-read sticky bits and to rx_full on an RXD read.
- RX capture: on rx_valid, rx_hold<=rx_data and rx_full<=1. If rx_full was already 1 and not being cleared this cycle, also set rx_ovr; the new byte overwrites the old one.
- TX FSM:
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: tx_data<=head byte, pop FIFO -> START.
  - START: tx_start=1 for exactly this cycle -> WAIT_HI.
  - WAIT_HI: tx_busy=1 -> WAIT_LO.
  - WAIT_LO: tx_busy=0 -> DONE.
  - DONE: set tx_done. FIFO non-empty -> LOAD, else -> IDLE.
- Latency: a TXD write into an empty FIFO with FSM IDLE gives tx_start high exactly 3 cycles after the write edge.
- Simultaneous push and pop on a full FIFO (LOAD cycle): the push is accepted with no overflow. Pointers wrap modulo FIFO_DEPTH.
- tx_busy already high on entry to WAIT_HI is accepted in that cycle.
- irq = (tx_ie & tx_done) | (rx_ie & rx_full), registered, so it updates one cycle after its source bits.
- Reset mid-transfer aborts immediately: pending FIFO bytes are lost and tx_start is not reissued.

Test Plan:
- Reset, then read CON at BASE+8 -> rdata=0, irq=0, tx_start=0.
- Write 0x55 to TXD, model sender busy for 10 cycles -> tx_start pulse at cycle +3 with tx_data=0x55, tx_done=1 one cycle after busy falls; a CON read returns bit2=1, the next read returns bit2=0.
- Write 5 bytes 0x01..0x05 back-to-back with sender busy -> bytes sent in order; the 5th write is dropped only if the FIFO holds 4 at that edge, and CON bit6 then reads 1.
- rx_valid with 0xA3, CON=0x2 -> rx_full=1, irq=1 next cycle; RXD read returns 0x000000A3 and irq falls.
- Two rx_valid pulses (0x11 then 0x22) without an RXD read -> RXD=0x22, CON bit7=1. An rx_valid coincident with an RXD read -> rx_full stays 1.
- Assert reset during WAIT_LO with 2 bytes queued -> all outputs 0 immediately; after release, no tx_start without a new TXD write.
